// File: rtl/div32_seq_ctrl_pkg.sv
// Shared definitions for the sequential signed 32-bit divider: widths,
// FSM state encoding and the adder-operand bundle used by the input mux.
// Optional feature macro: DIV_ZERO_FAST_EN (fast divide-by-zero exit).
package div_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] ITER_LAST = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ABS_A = 3'd1,
        S_ABS_B = 3'd2,
        S_ITER  = 3'd3,
        S_FIX_Q = 3'd4,
        S_FIX_R = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    // One operation for the shared adder: sum = a + b + cin
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
    } adder_op_t;

    // Adder operands for two's-complement negation: ~x + 0 + 1
    function automatic adder_op_t negate_op(input logic [WIDTH-1:0] x);
        adder_op_t op;
        op.a   = ~x;
        op.b   = {WIDTH{1'b0}};
        op.cin = 1'b1;
        return op;
    endfunction

endpackage

// File: rtl/div32_seq_ctrl_if.sv
// Handshake and data bus of the divider. The master side supplies operands
// and consumes results; the slave side is the divider itself.
// Optional feature macro: DIV_ZERO_FAST_EN adds the div_by_zero flag.
interface div32_seq_ctrl_if;
    import div_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
`ifdef DIV_ZERO_FAST_EN
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, busy, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, busy, div_by_zero
    );
`else
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, busy
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, busy
    );
`endif

endinterface

// File: rtl/cla_32_bit.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups whose group
// generate/propagate terms form the carry into the next group.
module cla_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] w_p;
    logic [31:0] w_g;
    logic [32:0] w_c;
    logic [3:0]  w_pb;
    logic [3:0]  w_gb;
    logic        w_ci;
    logic        w_gg;
    logic        w_gp;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Per-group lookahead carries, group carry chained into the next group
    always_comb begin
        w_c    = 33'd0;
        w_c[0] = cin;
        w_pb   = 4'd0;
        w_gb   = 4'd0;
        w_ci   = 1'b0;
        w_gg   = 1'b0;
        w_gp   = 1'b0;
        for (int grp = 0; grp < 8; grp++) begin
            w_pb = w_p[4*grp +: 4];
            w_gb = w_g[4*grp +: 4];
            w_ci = w_c[4*grp];
            w_c[4*grp+1] = w_gb[0] | (w_pb[0] & w_ci);
            w_c[4*grp+2] = w_gb[1] | (w_pb[1] & w_gb[0]) | (w_pb[1] & w_pb[0] & w_ci);
            w_c[4*grp+3] = w_gb[2] | (w_pb[2] & w_gb[1]) | (w_pb[2] & w_pb[1] & w_gb[0])
                         | (w_pb[2] & w_pb[1] & w_pb[0] & w_ci);
            w_gg = w_gb[3] | (w_pb[3] & w_gb[2]) | (w_pb[3] & w_pb[2] & w_gb[1])
                 | (w_pb[3] & w_pb[2] & w_pb[1] & w_gb[0]);
            w_gp = &w_pb;
            w_c[4*grp+4] = w_gg | (w_gp & w_ci);
        end
    end

    assign sum  = w_p ^ w_c[31:0];
    assign cout = w_c[32];

endmodule

// File: rtl/div32_seq_ctrl_step.sv
// One restoring-division step around the shared adder: forms the shifted
// partial remainder fed to the adder and picks trial or shifted value
// depending on the adder carry (carry = shifted remainder >= |b|).
module div32_step
    import div_pkg::*;
(
    input  logic [WIDTH-1:0] i_r,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_sum,
    input  logic             i_cout,
    output logic [WIDTH-1:0] o_r_sh,
    output logic [WIDTH-1:0] o_r_next,
    output logic [WIDTH-1:0] o_q_next
);

    assign o_r_sh = {i_r[WIDTH-2:0], i_q[WIDTH-1]};

    // Keep the trial difference when it did not borrow, else restore
    always_comb begin
        o_r_next = o_r_sh;
        o_q_next = {i_q[WIDTH-2:0], 1'b0};
        if (i_cout) begin
            o_r_next = i_sum;
            o_q_next = {i_q[WIDTH-2:0], 1'b1};
        end else begin
            o_r_next = o_r_sh;
            o_q_next = {i_q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div32_seq_ctrl.sv
// Multi-cycle signed 32-bit divider controller. One shared adder is
// sequenced through operand negation, 32 restoring steps and result sign
// fix-up; quotient truncates toward zero, remainder takes the dividend sign.
// Optional feature macro: DIV_ZERO_FAST_EN (divisor 0 exits straight to DONE
// with a div_by_zero flag).
module div32_seq_ctrl
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    div32_seq_ctrl_if.slave bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a, w_a_nxt;
    logic [WIDTH-1:0] r_b, w_b_nxt;
    logic [WIDTH-1:0] r_r, w_r_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_q_neg, w_q_neg_nxt;
    logic             r_r_neg, w_r_neg_nxt;
    logic             r_dz, w_dz_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic             w_accept;

    adder_op_t        w_add;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_r_sh;
    logic [WIDTH-1:0] w_r_step;
    logic [WIDTH-1:0] w_q_step;

    assign w_accept = bus.in_valid & r_in_ready;

    cla_32_bit u_adder (
        .a    (w_add.a),
        .b    (w_add.b),
        .cin  (w_add.cin),
        .sum  (w_sum),
        .cout (w_cout)
    );

    div32_step u_step (
        .i_r      (r_r),
        .i_q      (r_q),
        .i_sum    (w_sum),
        .i_cout   (w_cout),
        .o_r_sh   (w_r_sh),
        .o_r_next (w_r_step),
        .o_q_next (w_q_step)
    );

    // Shared adder operand select: one operation per state, idle states zero
    always_comb begin
        w_add = '{a: 32'd0, b: 32'd0, cin: 1'b0};
        case (r_state)
            S_ABS_A: w_add = negate_op(r_a);
            S_ABS_B: w_add = negate_op(r_b);
            S_ITER:  w_add = '{a: w_r_sh, b: ~r_b, cin: 1'b1};
            S_FIX_Q: w_add = negate_op(r_q);
            S_FIX_R: w_add = negate_op(r_r);
            default: w_add = '{a: 32'd0, b: 32'd0, cin: 1'b0};
        endcase
    end

    // Next-state and next-datapath values for every state
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_r_nxt     = r_r;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_q_neg_nxt = r_q_neg;
        w_r_neg_nxt = r_r_neg;
        w_dz_nxt    = r_dz;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_a_nxt     = bus.dividend;
                    w_b_nxt     = bus.divisor;
                    w_q_neg_nxt = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    w_r_neg_nxt = bus.dividend[WIDTH-1];
                    w_dz_nxt    = 1'b0;
`ifdef DIV_ZERO_FAST_EN
                    if (bus.divisor == 32'd0) begin
                        w_state_nxt = S_DONE;
                        w_q_nxt     = 32'hFFFF_FFFF;
                        w_r_nxt     = bus.dividend;
                        w_dz_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = S_ABS_A;
                    end
`else
                    w_state_nxt = S_ABS_A;
`endif
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ABS_A: begin
                if (r_a[WIDTH-1]) begin
                    w_a_nxt = w_sum;
                end else begin
                    w_a_nxt = r_a;
                end
                w_state_nxt = S_ABS_B;
            end
            S_ABS_B: begin
                if (r_b[WIDTH-1]) begin
                    w_b_nxt = w_sum;
                end else begin
                    w_b_nxt = r_b;
                end
                w_r_nxt     = 32'd0;
                w_q_nxt     = r_a;
                w_cnt_nxt   = 5'd0;
                w_state_nxt = S_ITER;
            end
            S_ITER: begin
                w_r_nxt   = w_r_step;
                w_q_nxt   = w_q_step;
                w_cnt_nxt = r_cnt + 5'd1;
                if (r_cnt == ITER_LAST) begin
                    w_state_nxt = S_FIX_Q;
                end else begin
                    w_state_nxt = S_ITER;
                end
            end
            S_FIX_Q: begin
                if (r_q_neg) begin
                    w_q_nxt = w_sum;
                end else begin
                    w_q_nxt = r_q;
                end
                w_state_nxt = S_FIX_R;
            end
            S_FIX_R: begin
                if (r_r_neg) begin
                    w_r_nxt = w_sum;
                end else begin
                    w_r_nxt = r_r;
                end
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                    w_dz_nxt    = 1'b0;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers and handshake outputs decoded from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_r         <= 32'd0;
            r_q         <= 32'd0;
            r_cnt       <= 5'd0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_dz        <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_r         <= w_r_nxt;
            r_q         <= w_q_nxt;
            r_cnt       <= w_cnt_nxt;
            r_q_neg     <= w_q_neg_nxt;
            r_r_neg     <= w_r_neg_nxt;
            r_dz        <= w_dz_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.quotient  = r_q;
    assign bus.remainder = r_r;
`ifdef DIV_ZERO_FAST_EN
    assign bus.div_by_zero = r_dz;
`endif

endmodule

// File: tb/tb_div32_seq_ctrl.sv
// Self-checking bench for div32_seq_ctrl: directed cases plus random
// operands, compared against a signed-arithmetic reference model.
// Honours DIV_ZERO_FAST_EN the same way as the design.
module tb_div32_seq_ctrl;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    div32_seq_ctrl_if bus ();

    div32_seq_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: signed division in 64-bit arithmetic, truncated to 32 bits
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output int lat);
        longint sa, sb, tq, tr;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dz  = 1'b0;
        lat = 36;
        if (b == 32'd0) begin
`ifdef DIV_ZERO_FAST_EN
            q   = 32'hFFFF_FFFF;
            r   = a;
            dz  = 1'b1;
            lat = 0;
`else
            q = (sa < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF;
            r = a;
`endif
        end else begin
            tq = sa / sb;
            tr = sa % sb;
            q  = tq[31:0];
            r  = tr[31:0];
        end
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] eq, er;
        logic        edz;
        int          elat;
        int          k;
        model(a, b, eq, er, edz, elat);
        k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid  = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        chk("in_ready_after_accept", {31'd0, bus.in_ready}, 32'd0);
        k = 0;
        while (!bus.out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, elat);
        chk("quotient", bus.quotient, eq);
        chk("remainder", bus.remainder, er);
`ifdef DIV_ZERO_FAST_EN
        chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, edz});
`endif
        if (hold > 0) begin
            bus.in_valid = 1'b1;
            bus.dividend = ~a;
            bus.divisor  = b + 32'd3;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
                chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
                chk("hold_quotient", bus.quotient, eq);
                chk("hold_remainder", bus.remainder, er);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        chk("out_valid_after_handshake", {31'd0, bus.out_valid}, 32'd0);
        chk("busy_after_handshake", {31'd0, bus.busy}, 32'd0);
        if (k >= 100) begin
            reset_n = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_quotient"}, bus.quotient, 32'd0);
        chk({tag, "_remainder"}, bus.remainder, 32'd0);
`ifdef DIV_ZERO_FAST_EN
        chk({tag, "_div_by_zero"}, {31'd0, bus.div_by_zero}, 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] ra, rb;
        n_checks      = 0;
        n_errors      = 0;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = 32'd0;
        bus.divisor   = 32'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset_n = 1'b1;

        run_op(32'd100, 32'd7, 0);
        run_op(-32'sd100, 32'd7, 0);
        run_op(32'd100, -32'sd7, 0);
        run_op(-32'sd100, -32'sd7, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(32'h8000_0000, 32'd1, 0);
        run_op(32'd1000, 32'd33, 10);

        // Asynchronous reset in the middle of the iteration phase
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.dividend  = 32'd123456;
        bus.divisor   = 32'd789;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (17) @(negedge clk);
        chk("busy_mid_iter", {31'd0, bus.busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        run_op(32'd9, 32'd3, 0);

        run_op(32'd5, 32'd0, 0);
        run_op(-32'sd5, 32'd0, 0);

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) begin
                rb = 32'd0 - rb;
            end
            run_op(ra, rb, (i == 5) ? 3 : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
